// File: rtl/led_pattern_pkg.sv
// Shared mode encodings and helpers for the LED pattern generator.
package led_pattern_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] LP_OFF     = 3'd0;
    localparam logic [MODE_W-1:0] LP_ON      = 3'd1;
    localparam logic [MODE_W-1:0] LP_SYNC    = 3'd2;
    localparam logic [MODE_W-1:0] LP_ALT     = 3'd3;
    localparam logic [MODE_W-1:0] LP_CHASE   = 3'd4;
    localparam logic [MODE_W-1:0] LP_BREATHE = 3'd5;

    // Low-bit mask of the phase counter that must be all ones for a step.
    function automatic logic [7:0] rate_mask(input logic [2:0] rate);
        return 8'((9'd1 << rate) - 9'd1);
    endfunction

endpackage

// File: rtl/led_pattern_gen_pwm.sv
// Shared brightness PWM: free-running counter compared against a duty word.
module led_pwm #(
    parameter int PWM_W = 8
) (
    input  logic             xclk,
    input  logic             gsr,
    input  logic [PWM_W-1:0] duty_i,
    output logic             pwm_on_o
);

    logic [PWM_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge xclk) begin
        if (gsr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // All-ones duty must be solidly on, which a plain compare cannot reach.
    assign pwm_on_o = (&duty_i) || (cnt_q < duty_i);

endmodule

// File: rtl/led_pattern_gen.sv
// N-channel LED pattern generator: prescaled pattern ticks, run-time modes,
// and a shared PWM that brightness-scales every lit channel.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS  = 2,
    parameter int PRESC_DIV = 1000,
    parameter int PWM_W     = 8
) (
    input  logic                xclk,
    input  logic                gsr,
    input  logic [MODE_W-1:0]   mode_i,
    input  logic [2:0]          rate_i,
    input  logic [PWM_W-1:0]    bright_i,
    input  logic                load_i,
    output logic [NUM_LEDS-1:0] led_o,
    output logic                tick_o,
    output logic [MODE_W-1:0]   mode_o
);

    localparam int PRESC_W = $clog2(PRESC_DIV);
    localparam int IDX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(NUM_LEDS - 1);

    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [2:0]          rate_q, rate_d;
    logic [PWM_W-1:0]    bright_q, bright_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [7:0]          phase_q, phase_d;
    logic                blink_q, blink_d;
    logic [IDX_W-1:0]    chase_idx_q, chase_idx_d;
    logic [PWM_W-1:0]    ramp_q, ramp_d;
    logic                ramp_up_q, ramp_up_d;
    logic [NUM_LEDS-1:0] led_q, led_d;

    logic                tick;
    logic                step;
    logic [NUM_LEDS-1:0] pattern;
    logic [PWM_W-1:0]    duty;
    logic                pwm_on;

    assign tick = (presc_q == PRESC_MAX);
    assign step = tick && ((phase_q & rate_mask(rate_q)) == rate_mask(rate_q));
    assign duty = (mode_q == LP_BREATHE) ? ramp_q : bright_q;

    led_pwm #(
        .PWM_W(PWM_W)
    ) u_pwm (
        .xclk    (xclk),
        .gsr     (gsr),
        .duty_i  (duty),
        .pwm_on_o(pwm_on)
    );

    always_comb begin
        pattern = '0;
        case (mode_q)
            LP_ON:      pattern = '1;
            LP_SYNC:    pattern = {NUM_LEDS{blink_q}};
            LP_ALT: begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    pattern[i] = blink_q ^ i[0];
                end
            end
            LP_CHASE:   pattern = NUM_LEDS'(1) << chase_idx_q;
            LP_BREATHE: pattern = '1;
            default:    pattern = '0;
        endcase
    end

    always_comb begin
        mode_d      = mode_q;
        rate_d      = rate_q;
        bright_d    = bright_q;
        phase_d     = phase_q;
        blink_d     = blink_q;
        chase_idx_d = chase_idx_q;
        ramp_d      = ramp_q;
        ramp_up_d   = ramp_up_q;
        presc_d     = tick ? '0 : presc_q + 1'b1;
        led_d       = pattern & {NUM_LEDS{pwm_on}};

        if (tick) begin
            phase_d = phase_q + 8'd1;
            // Turn around at the endpoints so each value is visited once per sweep.
            if (&ramp_q) begin
                ramp_d    = ramp_q - 1'b1;
                ramp_up_d = 1'b0;
            end else if (ramp_q == '0) begin
                ramp_d    = ramp_q + 1'b1;
                ramp_up_d = 1'b1;
            end else if (ramp_up_q) begin
                ramp_d = ramp_q + 1'b1;
            end else begin
                ramp_d = ramp_q - 1'b1;
            end
        end

        if (step) begin
            blink_d     = ~blink_q;
            chase_idx_d = (chase_idx_q == IDX_MAX) ? '0 : chase_idx_q + 1'b1;
        end

        if (load_i) begin
            mode_d      = mode_i;
            rate_d      = rate_i;
            bright_d    = bright_i;
            presc_d     = '0;
            phase_d     = '0;
            blink_d     = 1'b0;
            chase_idx_d = '0;
            ramp_d      = '0;
            ramp_up_d   = 1'b1;
        end
    end

    always_ff @(posedge xclk) begin
        if (gsr) begin
            mode_q      <= LP_OFF;
            rate_q      <= '0;
            bright_q    <= '1;
            presc_q     <= '0;
            phase_q     <= '0;
            blink_q     <= 1'b0;
            chase_idx_q <= '0;
            ramp_q      <= '0;
            ramp_up_q   <= 1'b1;
            led_q       <= '0;
        end else begin
            mode_q      <= mode_d;
            rate_q      <= rate_d;
            bright_q    <= bright_d;
            presc_q     <= presc_d;
            phase_q     <= phase_d;
            blink_q     <= blink_d;
            chase_idx_q <= chase_idx_d;
            ramp_q      <= ramp_d;
            ramp_up_q   <= ramp_up_d;
            led_q       <= led_d;
        end
    end

    assign led_o  = led_q;
    assign tick_o = tick;
    assign mode_o = mode_q;

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised N-channel LED pattern generator, the successor to the fixed two-LED red/green flasher. It takes a mode word from the I2C/Wishbone control register (`MiscReg` path) and drives `NUM_LEDS` registered LED enables, which the top level routes to its output buffers. Patterns are selected at run time: off, steady, synchronous blink, alternating blink, chase and breathing. Every lit pattern is brightness-scaled by a shared PWM.

## Interface
- `NUM_LEDS`, 2: number of LED channels, 1..16.
- `PRESC_DIV`, 1000: `xclk` cycles per pattern tick, ≥2.
- `PWM_W`, 8: PWM/brightness resolution in bits.
- `xclk` in 1: system clock; all logic on its rising edge.
- `gsr` in 1: synchronous reset, active-high.
- `mode_i` in 3: pattern mode, encodings in package.
- `rate_i` in 3: blink/chase speed exponent.
- `bright_i` in `PWM_W`: brightness duty.
- `load_i` in 1: one-cycle strobe; latches `mode_i`/`rate_i`/`bright_i`.
- `led_o` out `NUM_LEDS`: LED enables, 1 = lit, registered.
- `tick_o` out 1: one-cycle pulse per pattern tick (debug/test).
- `mode_o` out 3: currently active mode (readback).

## Operation
- Registers: `mode_q` (3b), `rate_q` (3b), `bright_q` (`PWM_W`), prescaler `presc` (0..`PRESC_DIV`-1), `phase` (8b), `chase_idx` (0..`NUM_LEDS`-1), `ramp` (`PWM_W`) with `ramp_dir`, `pwm_cnt` (`PWM_W`).
- Prescaler: increments every cycle. On reaching `PRESC_DIV`-1 it wraps to 0 and `tick` asserts for that cycle.
- `phase` increments on each tick and wraps 255→0. `step` = tick AND the low `rate_q` bits of `phase` are all ones (rate 0 means every tick).
- Modes:
  - 0 OFF: all 0.
  - 1 ON: all lit.
  - 2 SYNC: all channels = `blink`.
  - 3 ALT: even-indexed channels = `blink`, odd-indexed = ~`blink`.
  - 4 CHASE: only channel `chase_idx` lit.
  - 5 BREATHE: all lit, with duty = `ramp`.
  - 6/7: reserved, treated as OFF.
- `blink` toggles on every `step`.
- CHASE: `chase_idx` advances by 1 on each `step` and wraps `NUM_LEDS`-1→0. With `NUM_LEDS`=1 it stays at 0.
- BREATHE: on each tick, `ramp` moves ±1. At all-ones it holds direction down; at 0 it holds direction up. No overshoot, no skipped values.
- PWM:
  - `pwm_cnt` is free-running, +1 per cycle, wraps.
  - `pwm_on` = (`duty` == all-ones) OR (`pwm_cnt` < `duty`).
  - `duty` = `ramp` in BREATHE, otherwise `bright_q`.
  - Duty 0 gives never lit; all-ones gives always lit.
- Output: `led_o` <= `pattern` & {`NUM_LEDS`{`pwm_on`}}.
- Load: on a `load_i` edge, latch the inputs. In the same edge, clear `phase`, `presc`, `blink`, `chase_idx`, `ramp`, and set `ramp_dir` to up. A load with unchanged values still restarts the pattern.
- `gsr` mid-operation: everything returns to reset values on that edge, overriding a simultaneous `load_i`.

## Timing
- Reset values:
  - `led_o` = 0, `tick_o` = 0, `mode_o` = 0.
  - `bright_q` = all-ones, `rate_q` = 0.
  - All counters 0, `ramp_dir` = up.
- Latency: a `load_i` accepted at edge k affects `led_o` at edge k+1. `mode_o` updates at edge k.
- `tick_o` is high for exactly 1 cycle in every `PRESC_DIV` cycles. The first tick after reset or load occurs at cycle `PRESC_DIV`-1.
- Blink half-period = `PRESC_DIV`·2^`rate_q` cycles. Breathe full period = 2·(2^`PWM_W`−1)·`PRESC_DIV` cycles.
- `pwm_cnt` is not cleared on load, so PWM phase stays continuous.

## Structure
- `led_pattern_pkg`: mode localparams (`LP_OFF`=0, `LP_ON`, `LP_SYNC`, `LP_ALT`, `LP_CHASE`, `LP_BREATHE`) and the mode width.
- One sub-module, `led_pwm`: free-running counter plus compare, with `duty` in and `pwm_on` out. Instantiated once and shared by all channels.
- Pattern generation and the prescaler stay in `led_pattern_gen`.

## Test plan
- Reset: assert `gsr` for 3 cycles, then release with no load. Expect `led_o`=0 and `mode_o`=0 indefinitely; `tick_o` pulses every `PRESC_DIV` cycles.
- SYNC: `NUM_LEDS`=4, `PRESC_DIV`=4, load mode 2, rate 1, bright 255. Expect `led_o` to alternate 1111/0000 every 8 cycles, with the first change 1 cycle after load.
- ALT and CHASE:
  - ALT, same setup with mode 3: `led_o` alternates 0101/1010.
  - CHASE, mode 4, rate 0: `led_o` sequence 0001→0010→0100→1000→0001, one step per 4 cycles.
- PWM: mode 1, `PWM_W`=8.
  - bright 64: `led_o` high exactly 64 of every 256 cycles.
  - bright 0: never high.
  - bright 255: always high.
- BREATHE: `PWM_W`=4, `PRESC_DIV`=2. `ramp` runs 0→15→0 over 60 cycles. Per-window high count follows the ramp, with no value skipped or repeated at the endpoints.
- Simultaneous events: `load_i` and `gsr` in the same cycle leave the block in reset state. A load in the same cycle as a tick restarts the pattern, and the next tick occurs `PRESC_DIV` cycles later.
